// File: rtl/or1200_keccak_cust5_resp.sv
// l.cust5 front end for a Keccak core: sequences absorb words into a small FIFO,
// captures the 512-bit digest and serves word reads (store ops) with 1-cycle latency.

module or1200_keccak_cust5_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [AW:0]             cnt_q;
    logic                    do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module or1200_keccak_cust5_resp (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    input  logic [4:0]   cmd_op,
    input  logic [5:0]   cmd_limm,
    input  logic [31:0]  cmd_data,
    output logic         cmd_stall,
    output logic [31:0]  rdata,
    output logic         rdata_valid,
    output logic         cmd_err,
    output logic         core_in_valid,
    output logic [31:0]  core_in_data,
    output logic         core_in_first,
    output logic         core_in_last,
    input  logic         core_in_ready,
    input  logic         core_out_valid,
    input  logic [511:0] core_out_data
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ABSORB,
        S_WAIT_DONE,
        S_READY
    } state_e;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [31:0] data;
    } absorb_t;

    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;

    state_e            state_q, state_d;
    logic [15:0][31:0] digest_q, digest_d;
    logic              digest_valid_q, digest_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              cmd_err_q, cmd_err_d;

    logic              is_start, is_middle, is_end, is_store, is_absorb;
    logic              accept;
    logic              fifo_push, fifo_empty, fifo_full;
    absorb_t           push_word, head_word;

    or1200_keccak_cust5_fifo #(
        .W     ($bits(absorb_t)),
        .DEPTH (4)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (push_word),
        .pop_i   (core_in_ready),
        .head_o  (head_word),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign core_in_valid = !fifo_empty;
    assign core_in_data  = head_word.data;
    assign core_in_first = head_word.first;
    assign core_in_last  = head_word.last;

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign cmd_err     = cmd_err_q;

    // Full stalls absorb ops even if the head pops this cycle: no bypass path.
    always_comb begin
        is_start  = (cmd_op == OP_START);
        is_middle = (cmd_op == OP_MIDDLE);
        is_end    = (cmd_op == OP_END);
        is_store  = (cmd_op == OP_STORE);
        is_absorb = is_start || is_middle || is_end;
        cmd_stall = cmd_valid && ((is_absorb && fifo_full) ||
                                  (is_store && (state_q == S_WAIT_DONE)));
        accept    = cmd_valid && !cmd_stall;
    end

    always_comb begin
        state_d        = state_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        rdata_d        = rdata_q;
        rdata_valid_d  = 1'b0;
        cmd_err_d      = 1'b0;
        fifo_push      = 1'b0;
        push_word      = '{first: 1'b0, last: 1'b0, data: cmd_data};

        if (accept) begin
            if (is_start) begin
                if (state_q == S_IDLE || state_q == S_READY) begin
                    fifo_push       = 1'b1;
                    push_word.first = 1'b1;
                    digest_valid_d  = 1'b0;
                    state_d         = S_ABSORB;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end else if (is_middle) begin
                if (state_q == S_ABSORB) begin
                    fifo_push = 1'b1;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end else if (is_end) begin
                if (state_q == S_ABSORB) begin
                    fifo_push      = 1'b1;
                    push_word.last = 1'b1;
                    state_d        = S_WAIT_DONE;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end else if (is_store) begin
                rdata_valid_d = 1'b1;
                if (cmd_limm[5:4] == 2'b00 && digest_valid_q) begin
                    rdata_d = digest_q[cmd_limm[3:0]];
                end else begin
                    rdata_d   = '0;
                    cmd_err_d = 1'b1;
                end
            end
        end

        // Commands accepted in WAIT_DONE never change state, so capture cannot collide.
        if (state_q == S_WAIT_DONE && core_out_valid) begin
            digest_d       = core_out_data;
            digest_valid_d = 1'b1;
            state_d        = S_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            rdata_q        <= rdata_d;
            rdata_valid_q  <= rdata_valid_d;
            cmd_err_q      <= cmd_err_d;
        end
    end
endmodule

// File: tb/tb_or1200_keccak_cust5_resp.sv
// Bench for or1200_keccak_cust5_resp: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.

module tb_or1200_keccak_cust5_resp;
    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MID    = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;

    localparam int PH_IDLE   = 0;
    localparam int PH_ABSORB = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_READY  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic [4:0]   cmd_op;
    logic [5:0]   cmd_limm;
    logic [31:0]  cmd_data;
    logic         cmd_stall;
    logic [31:0]  rdata;
    logic         rdata_valid;
    logic         cmd_err;
    logic         core_in_valid;
    logic [31:0]  core_in_data;
    logic         core_in_first;
    logic         core_in_last;
    logic         core_in_ready;
    logic         core_out_valid;
    logic [511:0] core_out_data;

    or1200_keccak_cust5_resp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_op         (cmd_op),
        .cmd_limm       (cmd_limm),
        .cmd_data       (cmd_data),
        .cmd_stall      (cmd_stall),
        .rdata          (rdata),
        .rdata_valid    (rdata_valid),
        .cmd_err        (cmd_err),
        .core_in_valid  (core_in_valid),
        .core_in_data   (core_in_data),
        .core_in_first  (core_in_first),
        .core_in_last   (core_in_last),
        .core_in_ready  (core_in_ready),
        .core_out_valid (core_out_valid),
        .core_out_data  (core_out_data)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase + word queue + digest array, updated once per cycle.
    int          mphase;
    logic [33:0] mq[$];
    logic [31:0] mdig[16];
    bit          mdv;
    logic [31:0] m_rdata;
    bit          m_rv, m_err;
    logic [33:0] seen[$];

    logic exp_stall, is_abs, is_st, acc;
    int   ph0;

    always @(negedge clk) begin
        is_abs    = (cmd_op == OP_START) || (cmd_op == OP_MID) || (cmd_op == OP_END);
        is_st     = (cmd_op == OP_STORE);
        exp_stall = cmd_valid && ((is_abs && mq.size() == 4) || (is_st && mphase == PH_WAIT));
        if (chk_en) begin
            chk("stall", 64'(cmd_stall), 64'(exp_stall));
            chk("in_valid", 64'(core_in_valid), 64'(mq.size() != 0));
            if (mq.size() != 0)
                chk("in_word", 64'({core_in_first, core_in_last, core_in_data}), 64'(mq[0]));
            chk("rdata", 64'(rdata), 64'(m_rdata));
            chk("rdata_valid", 64'(rdata_valid), 64'(m_rv));
            chk("cmd_err", 64'(cmd_err), 64'(m_err));
        end
        if (rst_n && core_in_valid && core_in_ready)
            seen.push_back({core_in_first, core_in_last, core_in_data});

        if (!rst_n) begin
            mphase = PH_IDLE;
            mq.delete();
            mdv = 0;
            foreach (mdig[i]) mdig[i] = '0;
            m_rdata = '0;
            m_rv = 0;
            m_err = 0;
        end else begin
            ph0   = mphase;
            acc   = cmd_valid && !exp_stall;
            m_rv  = 0;
            m_err = 0;
            if (mq.size() != 0 && core_in_ready) void'(mq.pop_front());
            if (acc) begin
                case (cmd_op)
                    OP_START:
                        if (ph0 == PH_IDLE || ph0 == PH_READY) begin
                            mq.push_back({2'b10, cmd_data});
                            mdv = 0;
                            mphase = PH_ABSORB;
                        end else m_err = 1;
                    OP_MID:
                        if (ph0 == PH_ABSORB) mq.push_back({2'b00, cmd_data});
                        else m_err = 1;
                    OP_END:
                        if (ph0 == PH_ABSORB) begin
                            mq.push_back({2'b01, cmd_data});
                            mphase = PH_WAIT;
                        end else m_err = 1;
                    OP_STORE: begin
                        m_rv = 1;
                        if (cmd_limm < 6'd16 && mdv) m_rdata = mdig[cmd_limm];
                        else begin
                            m_rdata = '0;
                            m_err = 1;
                        end
                    end
                    default: ;
                endcase
            end
            if (ph0 == PH_WAIT && core_out_valid) begin
                for (int i = 0; i < 16; i++) mdig[i] = core_out_data[32*i +: 32];
                mdv = 1;
                mphase = PH_READY;
            end
        end
    end

    // Issue one command at posedge+1, wait (bounded) until accepted; returns at posedge+1.
    task automatic issue(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_limm  = limm;
        cmd_data  = d;
        #2;
        while (cmd_stall && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (cmd_stall) chk("issue_timeout", 64'(cmd_stall), 64'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [33:0] expw;

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_op = '0; cmd_limm = '0; cmd_data = '0;
        core_in_ready = 0; core_out_valid = 0; core_out_data = '0;
        tick(2);
        chk_en = 1'b1;
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rvalid", 64'(rdata_valid), 64'd0);
        chk("rst_err", 64'(cmd_err), 64'd0);
        chk("rst_in_valid", 64'(core_in_valid), 64'd0);
        chk("rst_stall", 64'(cmd_stall), 64'd0);
        rst_n = 1;

        // middle in IDLE -> error pulse, nothing queued
        issue(OP_MID, 6'd0, 32'hDEAD);
        chk("idle_mid_err", 64'(cmd_err), 64'd1);
        chk("idle_mid_nopush", 64'(core_in_valid), 64'd0);
        tick(1);
        chk("err_one_cycle", 64'(cmd_err), 64'd0);

        // store with no digest
        issue(OP_STORE, 6'd0, 32'h0);
        chk("nodig_rdata", 64'(rdata), 64'd0);
        chk("nodig_rvalid", 64'(rdata_valid), 64'd1);
        chk("nodig_err", 64'(cmd_err), 64'd1);

        // absorb 1..7 with ready high
        core_in_ready = 1;
        seen.delete();
        issue(OP_START, 6'd0, 32'd1);
        for (int i = 2; i <= 6; i++) issue(OP_MID, 6'd0, 32'(i));
        issue(OP_END, 6'd0, 32'd7);
        tick(4);
        chk("abs7_count", 64'(seen.size()), 64'd7);
        for (int i = 0; i < 7 && i < seen.size(); i++) begin
            expw = {1'(i == 0), 1'(i == 6), 32'(i + 1)};
            chk("abs7_word", 64'(seen[i]), 64'(expw));
        end

        // store while waiting for digest stalls until capture
        for (int i = 0; i < 16; i++) core_out_data[32*i +: 32] = 32'h100 + 32'(i);
        cmd_valid = 1; cmd_op = OP_STORE; cmd_limm = 6'd3;
        repeat (3) begin
            tick(1);
            chk("wait_store_stall", 64'(cmd_stall), 64'd1);
        end
        core_out_valid = 1;
        #1;
        chk("capture_cycle_stall", 64'(cmd_stall), 64'd1);
        tick(1);
        core_out_valid = 0;
        chk("stall_after_capture", 64'(cmd_stall), 64'd0);
        tick(1);
        cmd_valid = 0;
        chk("wait_store_rdata", 64'(rdata), 64'h103);
        chk("wait_store_rvalid", 64'(rdata_valid), 64'd1);
        chk("wait_store_err", 64'(cmd_err), 64'd0);
        core_out_data = '0;
        tick(1);
        chk("rvalid_pulse", 64'(rdata_valid), 64'd0);
        chk("rdata_hold", 64'(rdata), 64'h103);

        issue(OP_STORE, 6'd15, 32'h0);
        chk("store15", 64'(rdata), 64'h10F);
        issue(OP_STORE, 6'd14, 32'h0);
        chk("store14", 64'(rdata), 64'h10E);
        issue(OP_STORE, 6'd0, 32'h0);
        chk("store0", 64'(rdata), 64'h100);
        issue(OP_STORE, 6'd15, 32'h0);
        chk("store15_again", 64'(rdata), 64'h10F);
        issue(OP_STORE, 6'd16, 32'h0);
        chk("limm16_rdata", 64'(rdata), 64'd0);
        chk("limm16_rvalid", 64'(rdata_valid), 64'd1);
        chk("limm16_err", 64'(cmd_err), 64'd1);

        // FIFO full with ready low, then drain
        core_in_ready = 0;
        seen.delete();
        issue(OP_START, 6'd0, 32'hA0);
        for (int i = 1; i <= 3; i++) issue(OP_MID, 6'd0, 32'hA0 + 32'(i));
        cmd_valid = 1; cmd_op = OP_MID; cmd_data = 32'hA4;
        #1;
        chk("full_stall", 64'(cmd_stall), 64'd1);
        tick(1);
        chk("full_stall_hold", 64'(cmd_stall), 64'd1);
        core_in_ready = 1;
        #1;
        chk("full_no_bypass", 64'(cmd_stall), 64'd1);
        tick(1);
        chk("full_stall_drop", 64'(cmd_stall), 64'd0);
        tick(1);
        cmd_valid = 0;
        issue(OP_MID, 6'd0, 32'hA5);
        issue(OP_END, 6'd0, 32'hA6);
        tick(6);
        chk("drain_count", 64'(seen.size()), 64'd7);
        for (int i = 0; i < 7 && i < seen.size(); i++) begin
            expw = {1'(i == 0), 1'(i == 6), 32'hA0 + 32'(i)};
            chk("drain_word", 64'(seen[i]), 64'(expw));
        end

        // reset mid-absorb drops queued words; later digest ignored
        core_out_valid = 1; core_out_data = {16{32'h5555_AAAA}};
        tick(1);
        core_out_valid = 0;
        core_in_ready = 0;
        issue(OP_START, 6'd0, 32'hB0);
        issue(OP_MID, 6'd0, 32'hB1);
        chk("pre_rst_in_valid", 64'(core_in_valid), 64'd1);
        rst_n = 0;
        tick(1);
        chk("rst_mid_in_valid", 64'(core_in_valid), 64'd0);
        rst_n = 1;
        core_out_valid = 1;
        tick(1);
        core_out_valid = 0;
        issue(OP_STORE, 6'd0, 32'h0);
        chk("post_rst_store_rdata", 64'(rdata), 64'd0);
        chk("post_rst_store_err", 64'(cmd_err), 64'd1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            cmd_valid = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 99);
            if (r < 15)      cmd_op = OP_START;
            else if (r < 45) cmd_op = OP_MID;
            else if (r < 58) cmd_op = OP_END;
            else if (r < 90) cmd_op = OP_STORE;
            else             cmd_op = 5'($urandom_range(0, 31));
            cmd_limm = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
            cmd_data = $urandom;
            core_in_ready = ($urandom_range(0, 9) < 6);
            core_out_valid = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 16; i++) core_out_data[32*i +: 32] = $urandom;
            tick(1);
        end
        cmd_valid = 0; core_out_valid = 0; rst_n = 1;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/or1200_keccak_cust5_resp.md
OR1200_KECCAK_CUST5_RESP -- requirements
Module: or1200_keccak_cust5_resp

Interface
REQ-001 SHALL provide port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL provide port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL provide port cmd_valid, input, 1: decoded l.cust5 command present.
REQ-004 SHALL provide port cmd_op, input, 5: l.cust5 op field; 00100 start, 00010 middle, 00001 end, 01000 store.
REQ-005 SHALL provide port cmd_limm, input, 6: l.cust5 limm field; store word index.
REQ-006 SHALL provide port cmd_data, input, 32: operand A value for absorb ops.
REQ-007 SHALL provide port cmd_stall, output, 1: command not accepted this cycle.
REQ-008 SHALL provide port rdata, output, 32: store read data.
REQ-009 SHALL provide port rdata_valid, output, 1: rdata valid (one-cycle pulse).
REQ-010 SHALL provide port cmd_err, output, 1: protocol-error pulse.
REQ-011 SHALL provide port core_in_valid, output, 1: absorb word offered to the keccak core.
REQ-012 SHALL provide port core_in_data, output, 32: absorb word.
REQ-013 SHALL provide port core_in_first, output, 1: word came from a start op.
REQ-014 SHALL provide port core_in_last, output, 1: word came from an end op.
REQ-015 SHALL provide port core_in_ready, input, 1: core consumes the offered word.
REQ-016 SHALL provide port core_out_valid, input, 1: digest valid (single-cycle strobe).
REQ-017 SHALL provide port core_out_data, input, 512: digest; word i = bits [32i+31:32i].

Function
REQ-018 SHALL treat a command as accepted iff cmd_valid=1 and cmd_stall=0; unknown cmd_op values are accepted and ignored, with no err.
REQ-019 SHALL implement states IDLE, ABSORB, WAIT_DONE and READY.
REQ-020 SHALL, on start in IDLE or READY, push {first=1,last=0,cmd_data}, clear digest_valid and go to ABSORB.
REQ-021 SHALL, on middle in ABSORB, push {0,0,cmd_data}; on end in ABSORB, push {0,1,cmd_data} and go to WAIT_DONE.
REQ-022 SHALL NOT push or change state on start in ABSORB/WAIT_DONE, or on middle/end outside ABSORB; instead pulse cmd_err for 1 cycle.
REQ-023 SHALL buffer absorb words in a 4-entry FIFO, 34 bits wide; core_in_valid = FIFO not empty; head drives core_in_data/first/last.
REQ-024 SHALL pop the FIFO head in a cycle where core_in_valid=1 and core_in_ready=1.
REQ-025 SHALL assert cmd_stall when the FIFO is full and cmd_op is start/middle/end, even if a pop occurs in the same cycle (no full-bypass).
REQ-026 SHALL allow simultaneous push and pop when not full; occupancy is unchanged.
REQ-027 SHALL, in WAIT_DONE on core_out_valid=1, capture core_out_data into the digest register, set digest_valid and go to READY; core_out_valid in other states is ignored.
REQ-028 SHALL assert cmd_stall for a store while in WAIT_DONE, until the cycle after digest capture.
REQ-029 SHALL, on an accepted store, drive rdata_valid=1 on the next cycle only (1-cycle latency) with rdata = digest word cmd_limm[3:0].
REQ-030 SHALL, for a store with cmd_limm[5:4]≠0 or digest_valid=0, return rdata=0 with rdata_valid=1 and pulse cmd_err in the same cycle.
REQ-031 SHALL NOT change state or digest on a store; repeated stores of the same index return the same value.
REQ-032 SHALL hold rdata at its last value while rdata_valid=0.

Reset
REQ-033 SHALL, on rst_n=0 at a clock edge, enter IDLE, empty the FIFO, clear digest_valid and the digest to 0, and clear rdata, rdata_valid, cmd_err and core_in_valid to 0; cmd_stall=0.
REQ-034 SHALL drop any in-flight absorb/wait on a reset mid-operation; a later core_out_valid is ignored (IDLE).

Verification
REQ-035 Scenario: core_in_ready=1; start 1, middle 2..6, end 7 -> core sees 1..7 in order, first only on 1, last only on 7, state WAIT_DONE.
REQ-036 Scenario: core_out_valid with word i = 0x100+i, then store limm 15, 14, 0 -> rdata 0x10F, 0x10E, 0x100, each one cycle after acceptance.
REQ-037 Scenario: core_in_ready=0; start+5 middles -> 4 accepted, cmd_stall=1 on the 5th; raise ready -> drains in order, stall drops.
REQ-038 Scenario: store during WAIT_DONE -> stalled until digest captured; then rdata = the captured word.
REQ-039 Scenario: store after reset, and store limm=16 in READY -> rdata=0, rdata_valid=1, cmd_err=1.
REQ-040 Scenario: middle in IDLE -> cmd_err pulse, no push; rst_n=0 during ABSORB with 2 words queued -> core_in_valid=0 next cycle.
